// File: rtl/fp21_closest_hit_pkg.sv
// Shared FP21 widths and state encoding for the closest-hit reducer.
// Provides the `FP21_EXP, `FP21_FRAC and `FP21_W macros along with the package.
`ifndef FP21_DEFINITIONS_VH
`define FP21_DEFINITIONS_VH
`define FP21_EXP 8
`define FP21_FRAC 12
`define FP21_W (1 + `FP21_EXP + `FP21_FRAC)
`endif

package fp21_closest_hit_pkg;

  // Unpacked form: signed exponent one bit wider, fraction with the hidden bit.
  localparam int unsigned EXP_W  = `FP21_EXP + 1;
  localparam int unsigned FRAC_W = `FP21_FRAC + 1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/fp21_less_than.sv
// Combinational strict a < b for unpacked FP21 values, honouring the sign.
module fp21_less_than
  import fp21_closest_hit_pkg::*;
(
  input  logic              a_sign,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic              b_sign,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [FRAC_W-1:0] b_frac,
  output logic              lt
);

  logic mag_lt;
  logic mag_eq;

  always_comb begin
    mag_eq = (a_exp == b_exp) && (a_frac == b_frac);
    mag_lt = ($signed(a_exp) < $signed(b_exp)) || ((a_exp == b_exp) && (a_frac < b_frac));
    unique case ({a_sign, b_sign})
      2'b10:   lt = 1'b1;
      2'b01:   lt = 1'b0;
      2'b00:   lt = mag_lt;
      default: lt = !mag_lt && !mag_eq;  // both negative: larger magnitude is smaller
    endcase
  end

endmodule

// File: rtl/fp21_closest_hit.sv
// Streaming min-reduction of FP21 hit distances, one result per packet.
// Optional upper bound on t enabled by defining FP21_CLOSEST_HIT_TMAX_EN.
module fp21_closest_hit
  import fp21_closest_hit_pkg::*;
#(
  parameter int unsigned ID_W  = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_last,
`ifdef FP21_CLOSEST_HIT_TMAX_EN
  input  logic              tmax_sign,
  input  logic [EXP_W-1:0]  tmax_exp,
  input  logic [FRAC_W-1:0] tmax_frac,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic [ID_W-1:0]   out_id,
  output logic [CNT_W-1:0]  out_count
);

  state_e             state_q;
  logic               best_valid_q;
  logic               best_sign_q;
  logic [EXP_W-1:0]   best_exp_q;
  logic [FRAC_W-1:0]  best_frac_q;
  logic [ID_W-1:0]    best_id_q;
  logic [CNT_W-1:0]   count_q;

  logic               beat, accept, take, cand_lt_best, tmax_ok, bv_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               nxt_sign;
  logic [EXP_W-1:0]   nxt_exp;
  logic [FRAC_W-1:0]  nxt_frac;
  logic [ID_W-1:0]    nxt_id;

  assign in_ready = (state_q == ST_ACCUM);

  fp21_less_than u_lt_best (
    .a_sign (in_sign),
    .a_exp  (in_exp),
    .a_frac (in_frac),
    .b_sign (best_sign_q),
    .b_exp  (best_exp_q),
    .b_frac (best_frac_q),
    .lt     (cand_lt_best)
  );

`ifdef FP21_CLOSEST_HIT_TMAX_EN
  logic              pkt_open_q;
  logic              tmax_sign_q, tmax_sign_cur;
  logic [EXP_W-1:0]  tmax_exp_q, tmax_exp_cur;
  logic [FRAC_W-1:0] tmax_frac_q, tmax_frac_cur;

  // The first beat of a packet uses the live bound; later beats use the captured one.
  always_comb begin
    tmax_sign_cur = pkt_open_q ? tmax_sign_q : tmax_sign;
    tmax_exp_cur  = pkt_open_q ? tmax_exp_q  : tmax_exp;
    tmax_frac_cur = pkt_open_q ? tmax_frac_q : tmax_frac;
  end

  fp21_less_than u_lt_tmax (
    .a_sign (in_sign),
    .a_exp  (in_exp),
    .a_frac (in_frac),
    .b_sign (tmax_sign_cur),
    .b_exp  (tmax_exp_cur),
    .b_frac (tmax_frac_cur),
    .lt     (tmax_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_open_q  <= 1'b0;
      tmax_sign_q <= 1'b0;
      tmax_exp_q  <= '0;
      tmax_frac_q <= '0;
    end else if (beat) begin
      pkt_open_q <= !in_last;
      if (!pkt_open_q) begin
        tmax_sign_q <= tmax_sign;
        tmax_exp_q  <= tmax_exp;
        tmax_frac_q <= tmax_frac;
      end
    end
  end
`else
  assign tmax_ok = 1'b1;
`endif

  always_comb begin
    beat      = in_valid && (state_q == ST_ACCUM);
    accept    = beat && !in_sign && tmax_ok;
    take      = accept && (!best_valid_q || cand_lt_best);
    bv_nxt    = best_valid_q || accept;
    count_nxt = (accept && (count_q != '1)) ? count_q + 1'b1 : count_q;
    nxt_sign  = take ? in_sign : best_sign_q;
    nxt_exp   = take ? in_exp  : best_exp_q;
    nxt_frac  = take ? in_frac : best_frac_q;
    nxt_id    = take ? in_id   : best_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      best_valid_q <= 1'b0;
      best_sign_q  <= 1'b0;
      best_exp_q   <= '0;
      best_frac_q  <= '0;
      best_id_q    <= '0;
      count_q      <= '0;
      out_valid    <= 1'b0;
      out_hit      <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_frac     <= '0;
      out_id       <= '0;
      out_count    <= '0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (beat) begin
            best_valid_q <= bv_nxt;
            count_q      <= count_nxt;
            best_sign_q  <= nxt_sign;
            best_exp_q   <= nxt_exp;
            best_frac_q  <= nxt_frac;
            best_id_q    <= nxt_id;
            if (in_last) begin
              state_q   <= ST_HOLD;
              out_valid <= 1'b1;
              out_hit   <= bv_nxt;
              out_count <= count_nxt;
              out_sign  <= bv_nxt && nxt_sign;
              out_exp   <= bv_nxt ? nxt_exp  : '0;
              out_frac  <= bv_nxt ? nxt_frac : '0;
              out_id    <= bv_nxt ? nxt_id   : '0;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q      <= ST_ACCUM;
            out_valid    <= 1'b0;
            best_valid_q <= 1'b0;
            count_q      <= '0;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: doc/fp21_closest_hit.md
Name: fp21_closest_hit

Overview:
Streaming min-reduction over unpacked FP21 hit distances (t values), one packet of candidates per ray. It is the consumer of the FP21 ordering: it accepts one candidate per cycle, keeps the smallest non-negative t and its primitive ID, and emits one result per packet. It sits after the ray/primitive intersection units and before shading.

Parameters:
ID_W, 16, width of the primitive ID carried with each candidate
CNT_W, 8, width of the per-packet accepted-hit counter (saturating)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  candidate beat valid
in_ready  out  1  block can accept a beat
in_sign  in  1  candidate t sign
in_exp  in  `exp+1 (signed)  candidate t exponent, unpacked FP21
in_frac  in  `frac+1  candidate t fraction, unpacked FP21
in_id  in  ID_W  primitive ID
in_last  in  1  final beat of the packet
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_hit  out  1  at least one candidate was accepted
out_sign/out_exp/out_frac  out  1/`exp+1/`frac+1  closest t
out_id  out  ID_W  ID of the closest t
out_count  out  CNT_W  number of accepted candidates, saturating

Behaviour:
- Reset is asynchronous and active-high on rst; the single clock is clk.
- Reset values:
  - state = ACCUM; in_ready = 1; out_valid = 0; out_hit = 0; out_count = 0.
  - out_sign/out_exp/out_frac/out_id = 0.
  - Internal best_valid = 0.
- FSM, two states:
  - ACCUM: in_ready = 1. Each cycle with in_valid & in_ready is one beat.
  - HOLD: in_ready = 0, out_valid = 1. Outputs are stable until out_ready. On out_valid & out_ready, go to ACCUM and clear best_valid and the count. The next beat can be accepted in the cycle after the handshake.
- Candidate acceptance on a beat:
  - Rejected if in_sign = 1 (behind the ray).
  - Otherwise accepted. It replaces best if best_valid = 0, or if it is strictly less than best.
  - Ordering: signed exp first, then frac when the exps are equal.
  - Ties keep the earlier candidate.
  - An accepted beat increments the count, saturating at 2^CNT_W-1.
- Last beat (in_last = 1):
  - The update is folded in the same cycle.
  - Next cycle: state = HOLD, out_hit = best_valid including this beat, out_* = the final best, out_count = the final count.
  - Latency is 1 cycle from the last beat to out_valid.
- A packet whose beats are all rejected gives out_hit = 0 and out_count = 0; out_sign/exp/frac/id are don't-care and driven 0.
- A last beat that is itself rejected still closes the packet.
- in_valid = 0 cycles leave the state unchanged. in_* are ignored while in_ready = 0.
- rst asserted mid-packet or in HOLD discards everything immediately and returns to the reset values.

Optional Feature:
FP21_CLOSEST_HIT_TMAX_EN
- Defined: adds input ports tmax_sign, tmax_exp, tmax_frac. They are sampled at the first beat of each packet and held for the rest of the packet. A candidate is also rejected when t >= tmax, using the same ordering; a negative tmax rejects everything.
- Undefined: no tmax ports and no upper bound.

Decomposition:
- Shared header definitions.vh: `exp, `frac, and a new `FP21_W (total packed width).
- New constant: state encodings ST_ACCUM / ST_HOLD.
- One natural sub-module: fp21_less_than, a combinational strict "a < b" for unpacked FP21 with sign handling. It is instantiated once, or twice with TMAX_EN.

Test Plan:
- Packet t = {exp 3 frac 0x100 id 7, exp 2 frac 0x7FF id 9, exp 2 frac 0x400 id 4 last} -> 1 cycle later out_valid=1, out_hit=1, exp 2 frac 0x400, id 4, count 3.
- Packet {sign=1 exp 0 id 1, sign=1 exp 5 id 2 last} -> out_hit=0, out_count=0, outputs 0.
- Tie: {exp 1 frac 0x10 id 5, exp 1 frac 0x10 id 6 last} -> out_id=5.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after the result -> out_valid and out_* stable, in_ready=0, in_valid beats ignored.
  - Release -> next packet starts fresh.
- Assert rst mid-packet after 2 beats, then send single beat {exp -2 frac 0x1 id 3 last} -> result id 3, count 1, no residue from the first packet.
- Saturation (CNT_W=2): 5 accepted beats -> out_count=3.
- Back-to-back: two packets with out_ready tied 1 -> out_valid pulses one cycle per packet, with correct independent results.
